// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM states, RV32I opcodes, ALU and immediate encodings for multicycle_control
package ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE};
    endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps opcode, funct3 and funct7[5] to the ALU operation code
// Ports: op_i opcode, funct3_i, funct7b5_i instruction bit 30, alu_control_o ALU operation
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_control_o
);
    logic [3:0] f3_op;

    // bit 30 selects SUB only for register-register ops; for immediates it is part of the constant
    always_comb begin
        case (funct3_i)
            3'b000:  f3_op = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    end

    assign alu_control_o = (op_i == OP_R || op_i == OP_I) ? f3_op :
                           (op_i == OP_BRANCH)            ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control FSM with memory handshakes and retire counter
// Inputs: clk_i, rst_ni (sync, active-low), instr_i, imem_ack_i, dmem_ack_i, zero_i
// Outputs: imem_req_o, dmem_req_o, dmem_we_o, pc_write_o, pc_src_o, jump_o, alu_src_o,
//          reg_write_o, pc_upp_src_o, imm_upp_src_o, alu_control_o, imm_src_o,
//          result_src_o, trap_o, instr_count_o
// Macro CTRL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of retiring as a NOP.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [D_WIDTH-1:0] instr_i,
    input  logic               imem_ack_i,
    input  logic               dmem_ack_i,
    input  logic               zero_i,
    output logic               imem_req_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic               pc_write_o,
    output logic               pc_src_o,
    output logic               jump_o,
    output logic               alu_src_o,
    output logic               reg_write_o,
    output logic               pc_upp_src_o,
    output logic               imm_upp_src_o,
    output logic [3:0]         alu_control_o,
    output logic [2:0]         imm_src_o,
    output logic               result_src_o,
    output logic               trap_o,
    output logic [D_WIDTH-1:0] instr_count_o
);
    state_e state_q, state_d;
    logic [D_WIDTH-1:0] ir_q, ir_d, cnt_q, cnt_d;
    logic [6:0] op;
    logic [3:0] alu_dec;
    logic is_store;
    logic unused_ir;

    assign op = ir_q[6:0];
    assign is_store = (op == OP_STORE);
    assign unused_ir = ^{ir_q[D_WIDTH-1:31], ir_q[29:15], ir_q[11:7]};

    alu_decoder u_alu_dec (
        .op_i          (op),
        .funct3_i      (ir_q[14:12]),
        .funct7b5_i    (ir_q[30]),
        .alu_control_o (alu_dec)
    );

    // outputs are forced low while reset is held so a pending request drops immediately
    always_comb begin
        state_d = state_q;
        ir_d = ir_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o = 1'b0;
        pc_write_o = 1'b0;
        pc_src_o = 1'b0;
        jump_o = 1'b0;
        alu_src_o = 1'b0;
        reg_write_o = 1'b0;
        pc_upp_src_o = 1'b0;
        imm_upp_src_o = 1'b0;
        alu_control_o = ALU_ADD;
        imm_src_o = IMM_I;
        result_src_o = 1'b0;
        trap_o = 1'b0;
        if (rst_ni) begin
            case (state_q)
                S_FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        ir_d = instr_i;
                        state_d = S_DECODE;
                    end
                end
`ifdef CTRL_TRAP_EN
                S_DECODE: state_d = is_legal(op) ? S_EXEC : S_TRAP;
`else
                S_DECODE: state_d = S_EXEC;
`endif
                S_EXEC: begin
                    alu_control_o = alu_dec;
                    state_d = S_FETCH;
                    case (op)
                        OP_R: {reg_write_o, pc_write_o} = 2'b11;
                        OP_I: {alu_src_o, reg_write_o, pc_write_o} = 3'b111;
                        OP_LUI: begin
                            {imm_upp_src_o, reg_write_o, pc_write_o} = 3'b111;
                            imm_src_o = IMM_U;
                        end
                        OP_AUIPC: begin
                            {pc_upp_src_o, alu_src_o, reg_write_o, pc_write_o} = 4'b1111;
                            imm_src_o = IMM_U;
                        end
                        OP_JAL: begin
                            {jump_o, reg_write_o, pc_write_o, pc_src_o} = 4'b1111;
                            imm_src_o = IMM_J;
                        end
                        OP_JALR: {jump_o, alu_src_o, reg_write_o, pc_write_o, pc_src_o} = 5'b11111;
                        OP_BRANCH: begin
                            pc_write_o = 1'b1;
                            pc_src_o = ir_q[12] ? ~zero_i : zero_i;
                            imm_src_o = IMM_B;
                        end
                        OP_LOAD: begin
                            alu_src_o = 1'b1;
                            state_d = S_MEM;
                        end
                        OP_STORE: begin
                            alu_src_o = 1'b1;
                            imm_src_o = IMM_S;
                            state_d = S_MEM;
                        end
                        default: pc_write_o = 1'b1;
                    endcase
                end
                S_MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o = is_store;
                    if (dmem_ack_i) begin
                        pc_write_o = is_store;
                        state_d = is_store ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    {reg_write_o, result_src_o, pc_write_o} = 3'b111;
                    state_d = S_FETCH;
                end
`ifdef CTRL_TRAP_EN
                S_TRAP: trap_o = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign cnt_d = cnt_q + D_WIDTH'(pc_write_o);
    assign instr_count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            ir_q <= D_WIDTH'(NOP);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven and randomized checks of multicycle_control
module tb_multicycle_control;
    logic clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, zero = 1'b0;
    logic [31:0] instr = '0;
    logic imem_req, dmem_req, dmem_we, pc_write, pc_src, jump, alu_src, reg_write;
    logic pc_upp_src, imm_upp_src, result_src, trap;
    logic [3:0] alu_control;
    logic [2:0] imm_src;
    logic [31:0] instr_count;
    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    multicycle_control #(.D_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .imem_ack_i(imem_ack),
        .dmem_ack_i(dmem_ack), .zero_i(zero), .imem_req_o(imem_req), .dmem_req_o(dmem_req),
        .dmem_we_o(dmem_we), .pc_write_o(pc_write), .pc_src_o(pc_src), .jump_o(jump),
        .alu_src_o(alu_src), .reg_write_o(reg_write), .pc_upp_src_o(pc_upp_src),
        .imm_upp_src_o(imm_upp_src), .alu_control_o(alu_control), .imm_src_o(imm_src),
        .result_src_o(result_src), .trap_o(trap), .instr_count_o(instr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] outv();
        return {imem_req, dmem_req, dmem_we, pc_write, pc_src, jump, alu_src, reg_write,
                pc_upp_src, imm_upp_src, alu_control, imm_src, result_src, trap};
    endfunction

    // expected EXEC-cycle outputs derived from the instruction fields
    function automatic logic [18:0] model_exec(input logic [31:0] i, input logic z);
        logic [6:0] op;
        logic [2:0] f3, imm;
        logic [3:0] alu;
        logic pcw, pcs, j, src, rw, pu, iu;
        op = i[6:0];
        f3 = i[14:12];
        case (f3)
            3'd0: alu = (op == 7'h33 && i[30]) ? 4'd1 : 4'd0;
            3'd1: alu = 4'd7;
            3'd2: alu = 4'd5;
            3'd3: alu = 4'd6;
            3'd4: alu = 4'd4;
            3'd5: alu = i[30] ? 4'd9 : 4'd8;
            3'd6: alu = 4'd3;
            default: alu = 4'd2;
        endcase
        if (op != 7'h33 && op != 7'h13) alu = (op == 7'h63) ? 4'd1 : 4'd0;
        {pcw, pcs, j, src, rw, pu, iu} = '0;
        imm = 3'd0;
        case (op)
            7'h33: {pcw, rw} = 2'b11;
            7'h13: {pcw, rw, src} = 3'b111;
            7'h37: begin {pcw, rw, iu} = 3'b111; imm = 3'd3; end
            7'h17: begin {pcw, rw, pu, src} = 4'b1111; imm = 3'd3; end
            7'h6F: begin {pcw, rw, pcs, j} = 4'b1111; imm = 3'd4; end
            7'h67: {pcw, rw, pcs, j, src} = 5'b11111;
            7'h63: begin pcw = 1'b1; pcs = (f3 == 3'd1) ? ~z : z; imm = 3'd2; end
            7'h03: src = 1'b1;
            7'h23: begin src = 1'b1; imm = 3'd1; end
            default: pcw = 1'b1;
        endcase
        return {3'b000, pcw, pcs, j, src, rw, pu, iu, alu, imm, 2'b00};
    endfunction

    // one full instruction starting at a negedge in FETCH; returns the EXEC-cycle outputs
    task automatic run(input logic [31:0] ins, input logic z, input int idly, input int ddly,
                       output logic [18:0] ex);
        logic [6:0] op;
        logic st;
        op = ins[6:0];
        st = (op == 7'h23);
        instr = ins;
        zero = z;
        for (int k = 0; k <= idly; k++) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            imem_ack = (k == idly);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        instr = $urandom;
        chk("decode_quiet", 32'(outv()), 32'd0);
        chk("count_pre", instr_count, exp_cnt);
        @(negedge clk);
        ex = outv();
        chk("exec_ctrl", 32'(ex), 32'(model_exec(ins, z)));
        if (op != 7'h03 && !st) exp_cnt++;
        @(negedge clk);
        if (op == 7'h03 || st) begin
            for (int k = 0; k <= ddly; k++) begin
                chk("mem_req", 32'({dmem_req, dmem_we}), 32'({1'b1, st}));
                dmem_ack = (k == ddly);
                #1;
                chk("mem_pcw", 32'(pc_write), 32'((k == ddly) && st));
                @(negedge clk);
            end
            dmem_ack = 1'b0;
            if (!st) begin
                chk("wb", 32'({reg_write, result_src, pc_write, dmem_req}), 32'b1110);
                @(negedge clk);
            end
            exp_cnt++;
        end
        chk("count_post", instr_count, exp_cnt);
        chk("refetch", 32'(imem_req), 32'd1);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic z;
        int idly;
        int ddly;
        logic [8:0] exp;
    } vec_t;

    vec_t tv[17];
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [18:0] ex;
        logic [31:0] ins;
        int nops;
        // expected fields: {ALUControl, ALUSrc, RegWrite, PCWrite, PCSrc, Jump}
        tv[0]  = '{32'h002081B3, 1'b0, 0, 0, 9'b0000_01100};
        tv[1]  = '{32'h402081B3, 1'b0, 0, 0, 9'b0001_01100};
        tv[2]  = '{32'h00500093, 1'b0, 1, 0, 9'b0000_11100};
        tv[3]  = '{32'h4030D093, 1'b0, 0, 0, 9'b1001_11100};
        tv[4]  = '{32'h40000093, 1'b0, 0, 0, 9'b0000_11100};
        tv[5]  = '{32'h0020F1B3, 1'b0, 0, 0, 9'b0010_01100};
        tv[6]  = '{32'h0020B1B3, 1'b0, 0, 0, 9'b0110_01100};
        tv[7]  = '{32'h00208463, 1'b1, 0, 0, 9'b0001_00110};
        tv[8]  = '{32'h00208463, 1'b0, 0, 0, 9'b0001_00100};
        tv[9]  = '{32'h00209463, 1'b0, 0, 0, 9'b0001_00110};
        tv[10] = '{32'h00209463, 1'b1, 0, 0, 9'b0001_00100};
        tv[11] = '{32'h008000EF, 1'b0, 0, 0, 9'b0000_01111};
        tv[12] = '{32'h000080E7, 1'b0, 0, 0, 9'b0000_11111};
        tv[13] = '{32'h123450B7, 1'b0, 0, 0, 9'b0000_01100};
        tv[14] = '{32'h00001097, 1'b0, 0, 0, 9'b0000_11100};
        tv[15] = '{32'h0080A283, 1'b0, 0, 3, 9'b0000_10000};
        tv[16] = '{32'h0050A423, 1'b0, 2, 0, 9'b0000_10000};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(outv()), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_req", 32'(imem_req), 32'd1);
        @(negedge clk);

        for (int t = 0; t < 17; t++) begin
            run(tv[t].ins, tv[t].z, tv[t].idly, tv[t].ddly, ex);
            chk($sformatf("table_%0d", t), 32'({ex[8:5], ex[12], ex[11], ex[15], ex[14], ex[13]}),
                32'(tv[t].exp));
        end

        instr = 32'h002081B3;
        imem_ack = 1'b1;
        @(negedge clk);
        instr = 32'h008000EF;
        dmem_ack = 1'b1;
        chk("stray_ack_decode", 32'(outv()), 32'd0);
        @(negedge clk);
        chk("stray_ack_exec", 32'(outv()), 32'(model_exec(32'h002081B3, 1'b0)));
        exp_cnt++;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_count", instr_count, exp_cnt);
        chk("stray_ack_refetch", 32'(imem_req), 32'd1);

`ifdef CTRL_TRAP_EN
        nops = 9;
`else
        nops = 10;
`endif
        for (int r = 0; r < 150; r++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, nops - 1)];
            if (ins[6:0] == 7'h63) ins[14:12] = {2'b00, 1'($urandom_range(0, 1))};
            run(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), ex);
        end

`ifdef CTRL_TRAP_EN
        instr = 32'hFFFFFFFF;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("trap_decode", 32'(outv()), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("trap_hold", 32'({trap, imem_req, dmem_req, pc_write}), 32'b1000);
            chk("trap_count", instr_count, exp_cnt);
            imem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("trap_cleared", 32'(trap), 32'd0);
        rst_n = 1'b1;
        exp_cnt = '0;
        #1;
        chk("trap_refetch", 32'(imem_req), 32'd1);
        @(negedge clk);
`else
        run(32'hFFFFFFFF, 1'b0, 0, 0, ex);
        chk("nop_retire", 32'(ex[15]), 32'd1);
`endif

        instr = 32'h0080A283;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mem_before_reset", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mem_reset_req", 32'(dmem_req), 32'd0);
        chk("mem_reset_outputs", 32'(outv()), 32'd0);
        chk("mem_reset_count", instr_count, 32'd0);
        rst_n = 1'b1;
        exp_cnt = '0;
        #1;
        chk("mem_reset_fetch", 32'(imem_req), 32'd1);
        @(negedge clk);
        run(32'h002081B3, 1'b0, 0, 0, ex);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
